// File: rtl/game_board_writer_if.sv
// Button, detector and board signals between the game controller
// and its surroundings.
interface game_board_writer_if;
    logic            btn_next;
    logic            btn_place;
    logic            win;
    logic [8:0][1:0] matrizDeJuego;
    logic [3:0]      cursor;
    logic [1:0]      turno;
    logic            fin;
    logic            empate;
    logic            err;

    modport master (
        output btn_next, btn_place, win,
        input  matrizDeJuego, cursor, turno, fin, empate, err
    );

    modport slave (
        input  btn_next, btn_place, win,
        output matrizDeJuego, cursor, turno, fin, empate, err
    );
endinterface

// File: rtl/game_board_writer.sv
// Tic-tac-toe board writer: cursor, turns, move validation,
// turn timeout auto-placement and win/draw detection hand-off.
module game_board_writer #(
    parameter int TURN_CYCLES   = 250_000_000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    game_board_writer_if.slave bus
);
    localparam int TW = $clog2(TURN_CYCLES + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {TURN, SETTLE, DONE} state_t;

    state_t          state_q, state_d;
    logic [8:0][1:0] matrix_q, matrix_d;
    logic [3:0]      cursor_q, cursor_d;
    logic [1:0]      turno_q, turno_d;
    logic            fin_q, fin_d;
    logic            empate_q, empate_d;
    logic            err_q, err_d;
    logic [3:0]      count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            next_q, place_q;

    logic            next_p, place_p;
    logic [3:0]      free_idx;
    logic            free_found;
    logic [3:0]      wr_idx;
    logic            wr_en;

    assign next_p  = bus.btn_next & ~next_q;
    assign place_p = bus.btn_place & ~place_q;

    // Lowest empty cell, target of a timeout auto-placement.
    always_comb begin
        free_idx   = 4'd0;
        free_found = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!free_found && matrix_q[i] == 2'b00) begin
                free_idx   = 4'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        matrix_d = matrix_q;
        cursor_d = cursor_q;
        turno_d  = turno_q;
        fin_d    = fin_q;
        empate_d = empate_q;
        err_d    = 1'b0;
        count_d  = count_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        wr_en    = 1'b0;
        wr_idx   = cursor_q;

        unique case (state_q)
            TURN: begin
                if (place_p && matrix_q[cursor_q] == 2'b00) begin
                    wr_en  = 1'b1;
                    wr_idx = cursor_q;
                end else if (place_p) begin
                    err_d   = 1'b1;
                    timer_d = timer_q + 1'b1;
                end else if (timer_q >= TW'(TURN_CYCLES - 1)) begin
                    wr_en  = free_found;
                    wr_idx = free_idx;
                end else begin
                    if (next_p)
                        cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
                    timer_d = timer_q + 1'b1;
                end
                if (wr_en) begin
                    matrix_d[wr_idx] = turno_q;
                    count_d  = (count_q == 4'd9) ? 4'd9 : count_q + 4'd1;
                    timer_d  = '0;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                // The detector output lags the board, so sample on the last wait cycle.
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    if (bus.win) begin
                        fin_d   = 1'b1;
                        turno_d = 2'b00;
                        state_d = DONE;
                    end else if (count_q == 4'd9) begin
                        fin_d    = 1'b1;
                        empate_d = 1'b1;
                        turno_d  = 2'b00;
                        state_d  = DONE;
                    end else begin
                        turno_d = (turno_q == 2'b01) ? 2'b10 : 2'b01;
                        timer_d = '0;
                        state_d = TURN;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            DONE: begin
                if (place_p) begin
                    matrix_d = '0;
                    count_d  = 4'd0;
                    cursor_d = 4'd0;
                    turno_d  = 2'b01;
                    fin_d    = 1'b0;
                    empate_d = 1'b0;
                    timer_d  = '0;
                    state_d  = TURN;
                end
            end
            default: state_d = TURN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= TURN;
            matrix_q <= '0;
            cursor_q <= 4'd0;
            turno_q  <= 2'b01;
            fin_q    <= 1'b0;
            empate_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= 4'd0;
            timer_q  <= '0;
            settle_q <= '0;
            next_q   <= 1'b0;
            place_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            matrix_q <= matrix_d;
            cursor_q <= cursor_d;
            turno_q  <= turno_d;
            fin_q    <= fin_d;
            empate_q <= empate_d;
            err_q    <= err_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            next_q   <= bus.btn_next;
            place_q  <= bus.btn_place;
        end
    end

    assign bus.matrizDeJuego = matrix_q;
    assign bus.cursor        = cursor_q;
    assign bus.turno         = turno_q;
    assign bus.fin           = fin_q;
    assign bus.empate        = empate_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_game_board_writer.sv
// Scoreboard bench for game_board_writer: a game-rules model predicts
// every visible board/status change; a monitor checks each one.
module tb_game_board_writer;
    localparam int TC = 32;
    localparam int SC = 2;

    typedef struct packed {
        logic [8:0][1:0] mat;
        logic [3:0]      cur;
        logic [1:0]      turn;
        logic            fin;
        logic            emp;
        logic            err;
    } snap_t;

    localparam snap_t RST_SNAP = '{mat: '0, cur: 4'd0, turn: 2'b01,
                                   fin: 1'b0, emp: 1'b0, err: 1'b0};

    localparam int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                 '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_board_writer_if bus_if ();

    game_board_writer #(.TURN_CYCLES(TC), .SETTLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    function automatic bit has_line(logic [8:0][1:0] m);
        bit r = 0;
        for (int l = 0; l < 8; l++)
            if (m[LN[l][0]] != 2'b00 && m[LN[l][0]] == m[LN[l][1]] &&
                m[LN[l][1]] == m[LN[l][2]])
                r = 1;
        return r;
    endfunction

    // Winner detector stand-in: registered, one cycle behind the board.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus_if.win <= 1'b0;
        else     bus_if.win <= has_line(bus_if.matrizDeJuego);
    end

    // Game-rules reference model
    int mb [9];
    int mcur, mturn, mcount, mtimer, mphase, msettle;
    bit mfin, memp, merr;
    snap_t last_exp;
    snap_t expq [$];
    bit mon_en = 0;
    bit prev_n = 0, prev_p = 0;

    function automatic snap_t model_snap();
        snap_t s;
        for (int i = 0; i < 9; i++) s.mat[i] = 2'(mb[i]);
        s.cur = 4'(mcur); s.turn = 2'(mturn);
        s.fin = mfin; s.emp = memp; s.err = merr;
        return s;
    endfunction

    task automatic model_reset();
        foreach (mb[i]) mb[i] = 0;
        mcur = 0; mturn = 1; mcount = 0; mtimer = 0;
        mphase = 0; msettle = 0; mfin = 0; memp = 0; merr = 0;
    endtask

    task automatic place_at(int k);
        mb[k] = mturn; mcount++; mphase = 1; msettle = 0; mtimer = 0;
    endtask

    task automatic model_step(bit np, bit pp);
        snap_t s;
        int k;
        merr = 0;
        if (mphase == 0) begin
            if (pp && mb[mcur] == 0) place_at(mcur);
            else if (pp) begin merr = 1; mtimer++; end
            else if (mtimer >= TC - 1) begin
                k = 0;
                while (k < 8 && mb[k] != 0) k++;
                place_at(k);
            end else begin
                if (np) mcur = (mcur + 1) % 9;
                mtimer++;
            end
        end else if (mphase == 1) begin
            msettle++;
            if (msettle == SC) begin
                if (has_line(model_snap().mat)) begin
                    mfin = 1; mturn = 0; mphase = 2;
                end else if (mcount == 9) begin
                    mfin = 1; memp = 1; mturn = 0; mphase = 2;
                end else begin
                    mturn = 3 - mturn; mtimer = 0; mphase = 0;
                end
            end
        end else if (pp) begin
            model_reset();
        end
        s = model_snap();
        if (s != last_exp) begin
            expq.push_back(s);
            last_exp = s;
        end
    endtask

    // One clock of stimulus; entered and left at 1 time unit past posedge.
    task automatic tick(bit n, bit p);
        bit np, pp;
        bus_if.btn_next  = n;
        bus_if.btn_place = p;
        np = n & !prev_n;
        pp = p & !prev_p;
        prev_n = n; prev_p = p;
        model_step(np, pp);
        @(posedge clk); #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        rst = 1;
        bus_if.btn_next = 0; bus_if.btn_place = 0;
        prev_n = 0; prev_p = 0;
        #1;
        chk("rst_matrix", int'(bus_if.matrizDeJuego), 0);
        chk("rst_cursor", int'(bus_if.cursor), 0);
        chk("rst_turno", int'(bus_if.turno), 1);
        chk("rst_fin", int'(bus_if.fin), 0);
        chk("rst_empate", int'(bus_if.empate), 0);
        chk("rst_err", int'(bus_if.err), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        expq.delete();
        last_exp = model_snap();
        mon_en = 1;
    endtask

    task automatic press_next();
        tick(1, 0); tick(0, 0);
    endtask

    task automatic press_place();
        tick(0, 1); tick(0, 0); tick(0, 0); tick(0, 0);
    endtask

    task automatic goto_cell(int c);
        for (int i = 0; i < 9 && mcur != c; i++) press_next();
    endtask

    task automatic play(int c);
        goto_cell(c);
        press_place();
    endtask

    // Monitor: every visible change must match the next predicted one.
    snap_t prev_snap, cur_snap, exp_snap;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_snap = RST_SNAP;
        end else begin
            cur_snap = '{mat: bus_if.matrizDeJuego, cur: bus_if.cursor,
                         turn: bus_if.turno, fin: bus_if.fin,
                         emp: bus_if.empate, err: bus_if.err};
            if (cur_snap != prev_snap) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change got=%h exp=none", cur_snap);
                end else begin
                    exp_snap = expq.pop_front();
                    if (exp_snap != cur_snap) begin
                        failures++;
                        $display("FAIL board_state got=%h exp=%h", cur_snap, exp_snap);
                    end
                end
                prev_snap = cur_snap;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n;
        bus_if.btn_next = 0;
        bus_if.btn_place = 0;
        model_reset();
        last_exp = model_snap();
        @(posedge clk); #1;
        do_reset();

        // cursor walk and held button
        repeat (9) press_next();
        chk("cursor_wrap", int'(bus_if.cursor), 0);
        repeat (100) tick(1, 0);
        tick(0, 0);
        chk("cursor_held", int'(bus_if.cursor), 1);

        // placement then occupied placement
        do_reset();
        press_place();
        chk("cell0_p1", int'(bus_if.matrizDeJuego[0]), 1);
        chk("turno_p2", int'(bus_if.turno), 2);
        tick(0, 1);
        chk("err_pulse", int'(bus_if.err), 1);
        tick(0, 0);
        chk("err_once", int'(bus_if.err), 0);
        chk("cell0_kept", int'(bus_if.matrizDeJuego[0]), 1);

        // P1 wins on the top row
        do_reset();
        play(0); play(3); play(1); play(4); play(2);
        chk("win_fin", int'(bus_if.fin), 1);
        chk("win_empate", int'(bus_if.empate), 0);
        chk("win_turno", int'(bus_if.turno), 0);
        press_next();
        chk("win_frozen", int'(bus_if.matrizDeJuego), int'(18'b00_00_00_00_10_10_01_01_01));
        press_place();
        chk("win_cleared", int'(bus_if.matrizDeJuego), 0);

        // draw
        do_reset();
        foreach (LN[0][i]) ;
        play(0); play(1); play(2); play(4); play(3);
        play(5); play(7); play(6); play(8);
        chk("draw_fin", int'(bus_if.fin), 1);
        chk("draw_empate", int'(bus_if.empate), 1);

        // timeout auto-placement, then place on the expiry cycle
        do_reset();
        play(0); play(1); play(2);
        repeat (TC + 4) tick(0, 0);
        chk("auto_cell3", int'(bus_if.matrizDeJuego[3]), 2);
        chk("auto_turno", int'(bus_if.turno), 1);
        chk("auto_cursor", int'(bus_if.cursor), 2);
        goto_cell(5);
        for (int i = 0; i < TC && mtimer != TC - 1; i++) tick(0, 0);
        press_place();
        chk("expiry_cell5", int'(bus_if.matrizDeJuego[5]), 1);
        chk("expiry_cell4", int'(bus_if.matrizDeJuego[4]), 0);

        // reset in the middle of the settle wait
        do_reset();
        tick(0, 1);
        do_reset();
        chk("settle_rst_cell0", int'(bus_if.matrizDeJuego[0]), 0);

        // randomized play
        for (int op = 0; op < 300; op++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 59) == 0) do_reset();
            else if (r <= 3) begin
                tick(1, 0);
                repeat ($urandom_range(1, 2)) tick(0, 0);
            end else if (r <= 6) begin
                tick(0, 1); tick(0, 0);
            end else if (r == 7) begin
                n = $urandom_range(3, 20);
                repeat (n) tick(1, 0);
                tick(0, 0);
            end else if (r == 8) begin
                repeat ($urandom_range(1, 40)) tick(0, 0);
            end else begin
                tick(1, 1); tick(0, 0);
            end
        end
        repeat (4) tick(0, 0);
        @(negedge clk); #1;
        chk("queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
